feature_load_sequencer: RTL and testbench

Controller that sequences one sample through the 4-bank feature memory interface: it resets the memory, streams DIV_SIZE features into it under a valid/ready handshake, waits for the memory's write_done, then issues every row read address and forwards each 4-feature row to the HD encoder, with backpressure. It sits between the feature input stream and the encoder, and is the only master of the memory interface's reset, we, re, feature_in and read_address.

---
 rtl/feature_seq_pkg.sv | 26 ++
 rtl/feature_load_sequencer_if.sv | 47 ++++
 rtl/feature_skid_buffer.sv | 59 +++++
 rtl/feature_load_sequencer.sv | 147 ++++++++++++++
 tb/tb_feature_load_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/feature_seq_pkg.sv
// Shared types for the feature load sequencer: FSM states, default geometry
// and the row record carried from the memory banks to the encoder.
package feature_seq_pkg;

    localparam int DEF_DIV_SIZE    = 512;
    localparam int DEF_INOUT_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int ROWS            = DEF_DIV_SIZE / 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        LOAD      = 3'd2,
        WAIT_DONE = 3'd3,
        READ      = 3'd4,
        DRAIN     = 3'd5,
        FINISH    = 3'd6
    } state_e;

    // One memory row: {out3, out2, out1, out0} with out0 in the LSBs.
    typedef struct packed {
        logic [4*DEF_INOUT_WIDTH-1:0] data;
        logic                         last;
    } row_t;

endpackage

// File: rtl/feature_load_sequencer_if.sv
// Bundle of the feature input stream, the 4-bank memory port and the
// encoder row stream; master is the sequencer, slave is its environment.
interface feature_load_sequencer_if #(
    parameter int INOUT_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
);
    // Both streams use valid/ready: a beat transfers on a cycle where valid
    // and ready are both high; once valid rises, its payload holds until taken.
    logic                     in_valid;
    logic                     in_ready;
    logic [INOUT_WIDTH-1:0]   in_data;

    logic                     mem_reset;
    logic                     mem_we;
    logic                     mem_re;
    logic [INOUT_WIDTH-1:0]   mem_feature_in;
    logic [ADDR_WIDTH-1:0]    mem_read_address;
    logic                     mem_write_done;
    logic [INOUT_WIDTH-1:0]   mem_out0;
    logic [INOUT_WIDTH-1:0]   mem_out1;
    logic [INOUT_WIDTH-1:0]   mem_out2;
    logic [INOUT_WIDTH-1:0]   mem_out3;

    logic                     enc_valid;
    logic                     enc_ready;
    logic [4*INOUT_WIDTH-1:0] enc_data;
    logic                     enc_last;

    modport master (
        input  in_valid, in_data,
        input  mem_write_done, mem_out0, mem_out1, mem_out2, mem_out3,
        input  enc_ready,
        output in_ready,
        output mem_reset, mem_we, mem_re, mem_feature_in, mem_read_address,
        output enc_valid, enc_data, enc_last
    );

    modport slave (
        output in_valid, in_data,
        output mem_write_done, mem_out0, mem_out1, mem_out2, mem_out3,
        output enc_ready,
        input  in_ready,
        input  mem_reset, mem_we, mem_re, mem_feature_in, mem_read_address,
        input  enc_valid, enc_data, enc_last
    );

endinterface

// File: rtl/feature_skid_buffer.sv
// Two-entry FIFO of rows; holds read data that the encoder has not taken yet.
module feature_skid_buffer
    import feature_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  row_t       push_row_i,
    input  logic       pop_i,
    output logic       valid_o,
    output row_t       head_o,
    output logic [1:0] count_o
);

    row_t       entry_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // When full, a push is only legal alongside a pop that frees the slot.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_row_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/feature_load_sequencer.sv
// Sequences one sample through the 4-bank feature memory: clear, stream the
// features in, wait for write_done, then read every row out to the encoder.
module feature_load_sequencer
    import feature_seq_pkg::*;
#(
    parameter int DIV_SIZE    = DEF_DIV_SIZE,
    parameter int INOUT_WIDTH = DEF_INOUT_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   start_i,
    output logic   busy_o,
    output logic   done_o,
    output state_e state_o,
    feature_load_sequencer_if.master seq_if
);

    localparam int N_ROWS = DIV_SIZE / 4;
    localparam int WCW    = $clog2(DIV_SIZE) + 1;
    localparam int RCW    = ADDR_WIDTH + 1;
    localparam logic [WCW-1:0] LAST_BEAT = WCW'(DIV_SIZE - 1);
    localparam logic [RCW-1:0] LAST_ROW  = RCW'(N_ROWS - 1);

    state_e         state_q;
    logic [WCW-1:0] wr_cnt_q;
    logic [RCW-1:0] rd_cnt_q;
    logic           in_flight_q;
    logic           in_flight_last_q;

    logic           accept;
    logic           credit_ok;
    logic           issue;
    logic [1:0]     skid_count;
    logic           skid_valid;
    logic           skid_push;
    logic           skid_pop;
    logic           bypass;
    row_t           live_row;
    row_t           skid_head;
    row_t           out_row;

    assign accept = (state_q == LOAD) && seq_if.in_valid;

    // A read is only issued if its row is guaranteed a skid slot, so stalled
    // encoder backpressure can never cause read data to be dropped.
    assign credit_ok = (({1'b0, skid_count} + {2'b00, in_flight_q}) < 3'd2);
    assign issue     = (state_q == READ) && credit_ok;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            wr_cnt_q         <= '0;
            rd_cnt_q         <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            in_flight_q      <= issue;
            in_flight_last_q <= issue && (rd_cnt_q == LAST_ROW);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LAST_BEAT) begin
                            state_q <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (seq_if.mem_write_done) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (rd_cnt_q == LAST_ROW) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((skid_count == 2'd0) && !in_flight_q) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Row arriving from the banks this cycle (valid while in_flight_q).
    assign live_row = '{
        data: {seq_if.mem_out3, seq_if.mem_out2, seq_if.mem_out1, seq_if.mem_out0},
        last: in_flight_last_q
    };

    // An empty skid lets the arriving row go straight out; it is stored only
    // if the encoder does not take it in the same cycle.
    assign bypass    = in_flight_q && !skid_valid;
    assign skid_pop  = skid_valid && seq_if.enc_ready;
    assign skid_push = in_flight_q && !(bypass && seq_if.enc_ready);

    feature_skid_buffer u_skid (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (skid_push),
        .push_row_i (live_row),
        .pop_i      (skid_pop),
        .valid_o    (skid_valid),
        .head_o     (skid_head),
        .count_o    (skid_count)
    );

    assign out_row = skid_valid ? skid_head : live_row;

    assign seq_if.enc_valid        = skid_valid || in_flight_q;
    assign seq_if.enc_data         = seq_if.enc_valid ? out_row.data : '0;
    assign seq_if.enc_last         = seq_if.enc_valid && out_row.last;

    assign seq_if.in_ready         = (state_q == LOAD);
    assign seq_if.mem_reset        = (state_q == CLEAR);
    assign seq_if.mem_we           = accept;
    assign seq_if.mem_feature_in   = (state_q == LOAD) ? seq_if.in_data : '0;
    assign seq_if.mem_re           = issue;
    assign seq_if.mem_read_address = issue ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == FINISH);
    assign state_o = state_q;

endmodule

// File: tb/tb_feature_load_sequencer.sv
// Directed bench for feature_load_sequencer with a behavioural 4-bank memory
// and an expected-row queue.
module tb_feature_load_sequencer;
    import feature_seq_pkg::*;

    localparam int DIV = DEF_DIV_SIZE;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   start = 1'b0;
    logic   busy;
    logic   done;
    state_e dut_state;
    logic   model_rst = 1'b1;

    feature_load_sequencer_if #(.INOUT_WIDTH(32), .ADDR_WIDTH(8)) seq_if ();

    feature_load_sequencer #(.DIV_SIZE(DIV), .INOUT_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .state_o (dut_state),
        .seq_if  (seq_if)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [31:0] bank [4][256];
    logic [9:0]  wptr = '0;
    int          wd_wait = 0;
    int          wd_delay = 0;

    always @(posedge clk) begin
        if (model_rst || seq_if.mem_reset) begin
            wptr                  <= '0;
            wd_wait               <= 0;
            seq_if.mem_write_done <= 1'b0;
        end else begin
            if (seq_if.mem_we) begin
                bank[wptr[1:0]][wptr[9:2]] <= seq_if.mem_feature_in;
                wptr <= wptr + 10'd1;
            end
            if (wptr == 10'd512 && !seq_if.mem_write_done) begin
                if (wd_wait >= wd_delay) seq_if.mem_write_done <= 1'b1;
                else wd_wait <= wd_wait + 1;
            end
        end
        if (model_rst) begin
            seq_if.mem_out0 <= '0;
            seq_if.mem_out1 <= '0;
            seq_if.mem_out2 <= '0;
            seq_if.mem_out3 <= '0;
        end else if (seq_if.mem_re) begin
            seq_if.mem_out0 <= bank[0][seq_if.mem_read_address];
            seq_if.mem_out1 <= bank[1][seq_if.mem_read_address];
            seq_if.mem_out2 <= bank[2][seq_if.mem_read_address];
            seq_if.mem_out3 <= bank[3][seq_if.mem_read_address];
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] row_val(input int base, input int k);
        logic [31:0] f0, f1, f2, f3;
        f0 = 32'(base + 4 * k);
        f1 = 32'(base + 4 * k + 1);
        f2 = 32'(base + 4 * k + 2);
        f3 = 32'(base + 4 * k + 3);
        return {f3, f2, f1, f0};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [128:0] exp_q[$];
    logic [128:0] prev_row;
    logic [128:0] got_row;
    logic         stalled_prev;
    int mr_cnt, mr_first, ir_first, load_cyc, we_cnt, wait_cyc;
    int wd_first, re_first, re_early, iss, rows_acc, max_out, out_now;
    int done_cnt, done_cyc, last_acc, t0;
    int ready_mode = 0;
    int stall_left = 0;

    task automatic clear_stats();
        mr_cnt = 0; mr_first = -1; ir_first = -1; load_cyc = 0; we_cnt = 0;
        wait_cyc = 0; wd_first = -1; re_first = -1; re_early = 0; iss = 0;
        rows_acc = 0; max_out = 0; done_cnt = 0; done_cyc = -1; last_acc = -1;
        stalled_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        #2;
        if (seq_if.mem_reset) begin
            mr_cnt++;
            if (mr_first < 0) mr_first = cyc;
        end
        if (seq_if.in_ready) begin
            load_cyc++;
            if (ir_first < 0) ir_first = cyc;
            check_val("we_mirror", seq_if.mem_we, seq_if.in_valid);
            if (seq_if.in_valid) check_val("we_data", seq_if.mem_feature_in, seq_if.in_data);
        end
        if (seq_if.mem_we) we_cnt++;
        if (dut_state == WAIT_DONE) wait_cyc++;
        if (seq_if.mem_write_done && we_cnt == DIV && wd_first < 0) wd_first = cyc;
        if (seq_if.mem_re) begin
            if (re_first < 0) re_first = cyc;
            if (!seq_if.mem_write_done) re_early++;
        end
        out_now = iss - rows_acc;
        if (out_now > max_out) max_out = out_now;
        if (seq_if.mem_re) iss++;
        if (stalled_prev)
            check_val("stall_hold", {seq_if.enc_valid, seq_if.enc_last, seq_if.enc_data}, {1'b1, prev_row});
        if (seq_if.enc_valid && seq_if.enc_ready) begin
            got_row = {seq_if.enc_last, seq_if.enc_data};
            if (exp_q.size() == 0) check_val("extra_row", rows_acc + 1, ROWS);
            else check_val("row", got_row, exp_q.pop_front());
            rows_acc++;
            last_acc = cyc;
        end
        stalled_prev = seq_if.enc_valid && !seq_if.enc_ready;
        prev_row     = {seq_if.enc_last, seq_if.enc_data};
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- drivers ----------------
    initial begin
        seq_if.enc_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0 || rows_acc < 40) begin
                seq_if.enc_ready = 1'b1;
            end else if (stall_left > 0) begin
                seq_if.enc_ready = 1'b0;
                stall_left--;
            end else begin
                seq_if.enc_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_features(input int n, input int base, input bit gaps);
        int  sent = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        while (!seq_if.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (sent < n && guard < 5000) begin
            if (gaps && phase) begin
                seq_if.in_valid = 1'b0;
            end else begin
                seq_if.in_valid = 1'b1;
                seq_if.in_data  = 32'(base + sent);
            end
            if (seq_if.in_valid && seq_if.in_ready) sent++;
            phase = ~phase;
            guard++;
            @(negedge clk);
        end
        seq_if.in_valid = 1'b0;
        if (sent < n) check_val("send_timeout", sent, n);
    endtask

    task automatic poke_start();
        int g = 0;
        while (load_cyc < 50 && g < 2000) begin @(negedge clk); g++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (iss < 10 && g < 4000) begin @(negedge clk); g++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sample(input int base, input bit gaps, input bit poke, input int rmode, input int wdd);
        int guard;
        clear_stats();
        wd_delay   = wdd;
        ready_mode = rmode;
        stall_left = 20;
        for (int k = 0; k < ROWS; k++) exp_q.push_back({(k == ROWS - 1), row_val(base, k)});
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        fork
            send_features(DIV, base, gaps);
            if (poke) poke_start();
        join
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin @(negedge clk); guard++; end
        repeat (4) @(negedge clk);
        check_val("done_pulses", done_cnt, 1);
        check_val("mem_reset_pulses", mr_cnt, 1);
        check_val("mem_reset_cycle", mr_first - t0, 1);
        check_val("in_ready_cycle", ir_first - t0, 2);
        check_val("we_count", we_cnt, DIV);
        check_val("load_cycles", load_cyc, gaps ? 1023 : 512);
        check_val("wait_done_cycles", wait_cyc, wdd + 2);
        check_val("read_after_wd", re_first - wd_first, 1);
        check_val("re_before_wd", re_early, 0);
        check_val("rows_accepted", rows_acc, ROWS);
        check_val("rows_left", exp_q.size(), 0);
        check_val("max_outstanding", max_out, (rmode != 0) ? 2 : 1);
        if (rmode == 0) begin
            check_val("last_row_cycle", last_acc - re_first, ROWS);
            check_val("done_cycle", done_cyc - last_acc, 2);
        end
        check_val("idle_after", {busy, seq_if.in_ready, seq_if.enc_valid}, 3'b000);
        exp_q.delete();
        ready_mode = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        seq_if.in_valid = 1'b0;
        seq_if.in_data  = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_in_ready", seq_if.in_ready, 1'b0);
        check_val("rst_mem_reset", seq_if.mem_reset, 1'b0);
        check_val("rst_mem_we", seq_if.mem_we, 1'b0);
        check_val("rst_mem_re", seq_if.mem_re, 1'b0);
        check_val("rst_enc_valid", seq_if.enc_valid, 1'b0);
        check_val("rst_state", dut_state, IDLE);
        reset     = 1'b0;
        model_rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sample(0, 1'b0, 1'b0, 0, 0);      // nominal
        run_sample(2000, 1'b1, 1'b0, 0, 0);   // in_valid gaps
        run_sample(3000, 1'b0, 1'b0, 1, 0);   // encoder backpressure
        run_sample(4000, 1'b0, 1'b1, 0, 0);   // start while busy

        // Abort a load after 300 beats with reset, then run fresh data.
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_features(300, 500, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_state", dut_state, IDLE);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_mem_reset", seq_if.mem_reset, 1'b0);
        reset = 1'b0;
        clear_stats();
        repeat (6) @(negedge clk);
        check_val("abort_no_clear", mr_cnt, 0);
        check_val("abort_idle", {busy, seq_if.in_ready}, 2'b00);
        run_sample(1000, 1'b0, 1'b0, 0, 0);

        run_sample(6000, 1'b0, 1'b0, 0, 10); // slow write_done

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
